// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI transaction arbiter: FSM encoding, default
// start/done positions and the CONTROL byte layout used by SPI software.
package spi_ctrl_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_READ    = 3'd4;
  localparam logic [2:0] S_CAPTURE = 3'd5;
  localparam logic [2:0] S_ABORT   = 3'd6;

  typedef enum logic [2:0] {
    StIdle    = S_IDLE,
    StLoad    = S_LOAD,
    StStart   = S_START,
    StWait    = S_WAIT,
    StRead    = S_READ,
    StCapture = S_CAPTURE,
    StAbort   = S_ABORT
  } state_e;

  // CONTROL byte layout as seen by the SPI master and its configuring software.
  typedef struct packed {
    logic       start;
    logic [1:0] mode;
    logic       lsb_first;
    logic [3:0] prescale;
  } spi_ctrl_t;

  localparam logic [7:0]  DEF_START_MASK = 8'h80;
  localparam int unsigned DEF_DONE_BIT   = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from ptr_i+1 with wrap and
// returns the first requester as a one-hot grant and an index.
module rr_arbiter #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [IdxW-1:0] ptr_i,
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int unsigned off = 1; off <= N; off++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && req_i[i] && (i == ((32'(ptr_i) + off) % N))) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = IdxW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI master between N requesters: round-robin grant, then drives the
// WRITE / CONTROL / READ / CLR pins for one byte exchange and returns the rx byte.
module spi_txn_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned N          = 2,
  parameter logic [7:0]  START_MASK = DEF_START_MASK,
  parameter int unsigned DONE_BIT   = DEF_DONE_BIT,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic           CLK,
  input  logic           CLR_N,
  input  logic [N-1:0]   REQ,
  input  logic [8*N-1:0] REQ_DATA,
  input  logic [8*N-1:0] REQ_CFG,
  output logic [N-1:0]   GNT,
  output logic [N-1:0]   ACK,
  output logic           ERR,
  output logic [7:0]     RSP_DATA,
  output logic           BUSY,
  output logic           SPI_CLR,
  output logic           SPI_WRITE,
  output logic           SPI_READ,
  output logic [7:0]     SPI_CONTROL,
  output logic [7:0]     SPI_TX,
  input  logic [7:0]     SPI_STATUS,
  input  logic [7:0]     SPI_RX
);

  localparam int unsigned   IdxW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned   CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [N-1:0]    gnt_q, gnt_d, ack_q, ack_d;
  logic [7:0]      cfg_q, cfg_d, rsp_q, rsp_d, ctrl_q, ctrl_d, tx_q, tx_d;
  logic            err_q, err_d, busy_q, busy_d;
  logic            clr_q, clr_d, wr_q, wr_d, rd_q, rd_d, armed_q, armed_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [N-1:0]    rr_gnt;
  logic [IdxW-1:0] rr_idx;
  logic [7:0]      sel_data, sel_cfg;
  logic            done;
  logic            unused_status;

  assign done          = SPI_STATUS[DONE_BIT];
  assign unused_status = ^SPI_STATUS;

  rr_arbiter #(
    .N    (N),
    .IdxW (IdxW)
  ) u_rr (
    .ptr_i (ptr_q),
    .req_i (REQ),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx)
  );

  // Grant is one-hot, so OR-ing the masked lanes selects the winner's bytes.
  always_comb begin
    sel_data = '0;
    sel_cfg  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (rr_gnt[i]) begin
        sel_data = sel_data | REQ_DATA[8*i +: 8];
        sel_cfg  = sel_cfg | REQ_CFG[8*i +: 8];
      end
    end
  end

  // Next-state logic also computes the next value of every registered output.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cfg_d   = cfg_q;
    rsp_d   = rsp_q;
    ctrl_d  = ctrl_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    ack_d   = '0;
    err_d   = 1'b0;
    clr_d   = 1'b0;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (|REQ) begin
          state_d = StLoad;
          ptr_d   = rr_idx;
          gnt_d   = rr_gnt;
          cfg_d   = sel_cfg;
          tx_d    = sel_data;
          wr_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StLoad: begin
        state_d = StStart;
        ctrl_d  = cfg_q | START_MASK;
      end
      StStart: begin
        state_d = StWait;
        cnt_d   = '0;
        armed_d = 1'b0;
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        // A DONE still high from the previous byte must first be seen low.
        if (!done) armed_d = 1'b1;
        if (armed_q && done) begin
          state_d = StRead;
          rd_d    = 1'b1;
        end else if (cnt_q == CntLast) begin
          state_d = StAbort;
          clr_d   = 1'b1;
          ctrl_d  = '0;
          ack_d   = gnt_q;
          err_d   = 1'b1;
        end
      end
      StRead: begin
        state_d = StCapture;
        rsp_d   = SPI_RX;
        ack_d   = gnt_q;
        ctrl_d  = '0;
      end
      StCapture, StAbort: begin
        state_d = StIdle;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        busy_d  = 1'b0;
        ctrl_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= StIdle;
      ptr_q   <= IdxW'(N - 1);
      gnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      cfg_q   <= '0;
      rsp_q   <= '0;
      ctrl_q  <= '0;
      tx_q    <= '0;
      busy_q  <= 1'b0;
      clr_q   <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cfg_q   <= cfg_d;
      rsp_q   <= rsp_d;
      ctrl_q  <= ctrl_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      clr_q   <= clr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
    end
  end

  assign GNT         = gnt_q;
  assign ACK         = ack_q;
  assign ERR         = err_q;
  assign RSP_DATA    = rsp_q;
  assign BUSY        = busy_q;
  assign SPI_CLR     = clr_q;
  assign SPI_WRITE   = wr_q;
  assign SPI_READ    = rd_q;
  assign SPI_CONTROL = ctrl_q;
  assign SPI_TX      = tx_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter: directed scenarios plus randomized
// transactions checked against a cycle-budget model of grant order and latency.
module tb_spi_txn_arbiter;

  localparam int unsigned N  = 3;
  localparam int          TO = 16;
  localparam int unsigned DB = 3;
  localparam logic [7:0]  DoneMask = 8'h08;
  localparam logic [7:0]  StartMask = 8'h80;

  logic           CLK;
  logic           CLR_N;
  logic [N-1:0]   REQ;
  logic [8*N-1:0] REQ_DATA;
  logic [8*N-1:0] REQ_CFG;
  logic [N-1:0]   GNT;
  logic [N-1:0]   ACK;
  logic           ERR;
  logic [7:0]     RSP_DATA;
  logic           BUSY;
  logic           SPI_CLR;
  logic           SPI_WRITE;
  logic           SPI_READ;
  logic [7:0]     SPI_CONTROL;
  logic [7:0]     SPI_TX;
  logic [7:0]     SPI_STATUS;
  logic [7:0]     SPI_RX;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         ptr_m    = N - 1;
  logic [7:0] rsp_m    = 8'h00;

  spi_txn_arbiter #(
    .N          (N),
    .START_MASK (StartMask),
    .DONE_BIT   (DB),
    .TIMEOUT    (TO)
  ) dut (
    .CLK         (CLK),
    .CLR_N       (CLR_N),
    .REQ         (REQ),
    .REQ_DATA    (REQ_DATA),
    .REQ_CFG     (REQ_CFG),
    .GNT         (GNT),
    .ACK         (ACK),
    .ERR         (ERR),
    .RSP_DATA    (RSP_DATA),
    .BUSY        (BUSY),
    .SPI_CLR     (SPI_CLR),
    .SPI_WRITE   (SPI_WRITE),
    .SPI_READ    (SPI_READ),
    .SPI_CONTROL (SPI_CONTROL),
    .SPI_TX      (SPI_TX),
    .SPI_STATUS  (SPI_STATUS),
    .SPI_RX      (SPI_RX)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Other status bits always read the complement so a wrong bit index shows up.
  task automatic set_status(input bit done);
    SPI_STATUS = done ? DoneMask : ~DoneMask;
  endtask

  // Slave schedule, by clock edge k after the request is seen (k=0):
  // WAIT samples from edge 3; s stale-high edges, d low edges, then high.
  function automatic bit done_at(input int k, input int s, input int d, input bit never);
    if (k < 3) return 1'b1;
    if (never) return 1'b0;
    if (k < 3 + s) return 1'b1;
    if (k < 3 + s + d) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, 32'(GNT), 32'd0);
    check({tag, "_ack"}, 32'(ACK), 32'd0);
    check({tag, "_err"}, 32'(ERR), 32'd0);
    check({tag, "_rsp"}, 32'(RSP_DATA), 32'd0);
    check({tag, "_busy"}, 32'(BUSY), 32'd0);
    check({tag, "_clr"}, 32'(SPI_CLR), 32'd0);
    check({tag, "_wr"}, 32'(SPI_WRITE), 32'd0);
    check({tag, "_rd"}, 32'(SPI_READ), 32'd0);
    check({tag, "_ctrl"}, 32'(SPI_CONTROL), 32'd0);
    check({tag, "_tx"}, 32'(SPI_TX), 32'd0);
  endtask

  // Called in an IDLE cycle; the next rising edge is the one that sees the request.
  task automatic run_txn(input logic [N-1:0] req, input logic [8*N-1:0] data,
                         input logic [8*N-1:0] cfg, input logic [7:0] rx, input int s,
                         input int d, input bit never, input bit drop);
    int         w;
    int         ack_edge;
    bit         abort;
    int         n_rd;
    int         n_clr;
    int         n_ack;
    bit         gnt_ok;
    logic [N-1:0] g1h;
    logic [7:0] exp_rsp;
    w = -1;
    for (int k = 1; k <= int'(N); k++) begin
      if (w < 0 && req[(ptr_m + k) % N]) w = (ptr_m + k) % N;
    end
    ptr_m    = w;
    g1h      = '0;
    g1h[w]   = 1'b1;
    abort    = never || (s + d + 1 > TO);
    ack_edge = abort ? 2 + TO : 4 + s + d;
    exp_rsp  = abort ? rsp_m : rx;
    rsp_m    = exp_rsp;
    n_rd     = 0;
    n_clr    = 0;
    n_ack    = 0;
    gnt_ok   = 1'b1;
    REQ      = req;
    REQ_DATA = data;
    REQ_CFG  = cfg;
    SPI_RX   = rx;
    set_status(done_at(0, s, d, never));
    for (int e = 0; e <= ack_edge + 1; e++) begin
      @(posedge CLK);
      #1;
      set_status(done_at(e + 1, s, d, never));
      if (drop && e == 1) REQ[w] = 1'b0;
      // Change the request bytes after the latch; they must not leak through.
      if (e == 0) begin
        REQ_DATA = ~data;
        REQ_CFG  = ~cfg;
      end
      if (SPI_READ === 1'b1) n_rd++;
      if (SPI_CLR === 1'b1) n_clr++;
      if (ACK !== '0) n_ack++;
      if (e <= ack_edge && GNT !== g1h) gnt_ok = 1'b0;
      if (e == 0) begin
        check("load_gnt", 32'(GNT), 32'(g1h));
        check("load_write", 32'(SPI_WRITE), 32'd1);
        check("load_tx", 32'(SPI_TX), 32'(data[8*w +: 8]));
        check("load_busy", 32'(BUSY), 32'd1);
      end
      if (e == 1) begin
        check("start_write", 32'(SPI_WRITE), 32'd0);
        check("start_ctrl", 32'(SPI_CONTROL), 32'(cfg[8*w +: 8] | StartMask));
      end
      if (e == ack_edge - 1 && !abort) check("read_pulse", 32'(SPI_READ), 32'd1);
      if (e == ack_edge) begin
        check("ack", 32'(ACK), 32'(g1h));
        check("ack_err", 32'(ERR), 32'(abort));
        check("ack_clr", 32'(SPI_CLR), 32'(abort));
        check("ack_rsp", 32'(RSP_DATA), 32'(exp_rsp));
        check("ack_ctrl", 32'(SPI_CONTROL), 32'd0);
      end
      if (e == ack_edge + 1) begin
        check("post_gnt", 32'(GNT), 32'd0);
        check("post_busy", 32'(BUSY), 32'd0);
        check("post_err", 32'(ERR), 32'd0);
        check("post_rsp", 32'(RSP_DATA), 32'(exp_rsp));
      end
    end
    check("gnt_steady", 32'(gnt_ok), 32'd1);
    check("n_read", 32'(n_rd), abort ? 32'd0 : 32'd1);
    check("n_clr", 32'(n_clr), abort ? 32'd1 : 32'd0);
    check("n_ack", 32'(n_ack), 32'd1);
    REQ_DATA = data;
    REQ_CFG  = cfg;
  endtask

  initial begin
    CLR_N    = 1'b0;
    REQ      = '0;
    REQ_DATA = '0;
    REQ_CFG  = '0;
    SPI_RX   = 8'h00;
    set_status(1'b1);
    #3;
    check_reset_outputs("reset");
    #9;
    CLR_N = 1'b1;
    @(posedge CLK);
    #1;
    check("idle_busy", 32'(BUSY), 32'd0);

    // Contention from reset: grants must alternate 0,1,0,1.
    for (int t = 0; t < 4; t++) begin
      run_txn(3'b011, {8'h00, 8'h6C, 8'h54}, {8'h00, 8'h21, 8'h12}, 8'hA0 + 8'(t), 0, 1,
              1'b0, 1'b0);
    end

    // Single request with the reference bytes.
    REQ = '0;
    run_txn(3'b001, {8'h00, 8'h00, 8'h50}, {8'h00, 8'h00, 8'h64}, 8'h4D, 0, 2, 1'b0, 1'b0);

    // Stale DONE held high into WAIT for several cycles.
    run_txn(3'b100, {8'h33, 8'h00, 8'h00}, {8'h05, 8'h00, 8'h00}, 8'h99, 4, 3, 1'b0, 1'b0);

    // DONE on the final WAIT cycle wins over the timeout.
    run_txn(3'b010, {8'h00, 8'h11, 8'h00}, {8'h00, 8'h02, 8'h00}, 8'h5A, 0, TO - 1, 1'b0,
            1'b0);

    // Slave never completes: ABORT, then the next grant proceeds normally.
    run_txn(3'b001, {8'h00, 8'h00, 8'hC3}, {8'h00, 8'h00, 8'h01}, 8'hEE, 0, 1, 1'b1, 1'b0);
    run_txn(3'b011, {8'h00, 8'h77, 8'h66}, {8'h00, 8'h03, 8'h04}, 8'h3C, 1, 2, 1'b0, 1'b0);

    // REQ dropped in START: the transaction still completes.
    run_txn(3'b010, {8'h00, 8'hB1, 8'h00}, {8'h00, 8'h0F, 8'h00}, 8'h62, 0, 3, 1'b0, 1'b1);

    // Asynchronous reset in the middle of WAIT.
    REQ      = 3'b001;
    REQ_DATA = {8'h00, 8'h00, 8'hDE};
    REQ_CFG  = {8'h00, 8'h00, 8'h0A};
    set_status(1'b1);
    for (int e = 0; e < 4; e++) begin
      @(posedge CLK);
      #1;
      set_status(e < 1);
    end
    #1;
    CLR_N = 1'b0;
    REQ   = '0;
    #1;
    check_reset_outputs("midreset");
    #2;
    CLR_N = 1'b1;
    ptr_m = N - 1;
    rsp_m = 8'h00;
    for (int e = 0; e < 3; e++) begin
      @(posedge CLK);
      #1;
      check("quiet_ack", 32'(ACK), 32'd0);
      check("quiet_busy", 32'(BUSY), 32'd0);
    end
    run_txn(3'b111, {8'h03, 8'h02, 8'h01}, {8'h30, 8'h20, 8'h10}, 8'h81, 0, 2, 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int t = 0; t < 24; t++) begin
      logic [N-1:0] rq;
      rq = N'($urandom_range(1, (1 << N) - 1));
      if ($urandom_range(0, 3) == 0) begin
        REQ = '0;
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
          @(posedge CLK);
          #1;
          check("gap_busy", 32'(BUSY), 32'd0);
        end
      end
      run_txn(rq, (8 * N)'($urandom), (8 * N)'($urandom), 8'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(1, 5)),
              $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
